// File: rtl/fifo_filled_sync.sv
// fifo_filled_sync: single-clock FWFT FIFO with full/empty/filled flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_filled_sync #(
  parameter int SIZE_SCALE    = 8,
  parameter int WIDTH         = 30,
  parameter int FILLED_THRESH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enqueue,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  dequeue,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  filled,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [SIZE_SCALE:0]   count
);

  localparam int DEPTH = 1 << SIZE_SCALE;
  localparam logic [SIZE_SCALE:0] CNT_FULL = (SIZE_SCALE+1)'(DEPTH);
  localparam logic [SIZE_SCALE:0] CNT_THR  = (SIZE_SCALE+1)'(FILLED_THRESH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [SIZE_SCALE-1:0] wptr;
  logic [SIZE_SCALE-1:0] rptr;
  logic [SIZE_SCALE:0]   cnt;
  logic                  wr;
  logic                  rd;

  // Flags come only from the registered count.
  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_FULL);
  assign filled = (cnt >= CNT_THR);
  assign count  = cnt;

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign rd = dequeue & ~empty;
  assign wr = enqueue & (~full | rd);

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enqueue && !wr) begin
        overflow <= 1'b1;
      end
      if (dequeue && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_filled_sync.sv
// tb_fifo_filled_sync: randomized scoreboard bench for fifo_filled_sync.
// Queue model tracks contents; a negedge monitor checks flags and data.
module tb_fifo_filled_sync;

  localparam int SS    = 8;
  localparam int W     = 30;
  localparam int DEPTH = 256;
  localparam int THR   = 128;

  logic          clk;
  logic          rst_n;
  logic          enqueue;
  logic [W-1:0]  wdata;
  logic          dequeue;
  logic [W-1:0]  rdata;
  logic          full;
  logic          empty;
  logic          filled;
  logic [SS:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo_filled_sync #(
    .SIZE_SCALE(SS),
    .WIDTH(W),
    .FILLED_THRESH(THR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enqueue(enqueue),
    .wdata(wdata),
    .dequeue(dequeue),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .filled(filled),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(overflow),
    .underflow(underflow),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  bit m_ovf;
  bit m_udf;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // Apply the rules to the inputs present at this edge.
  function automatic void model_edge();
    bit rd_ok;
    bit wr_ok;
    rd_ok = dequeue && (mq.size() != 0);
    wr_ok = enqueue && ((mq.size() != DEPTH) || rd_ok);
    if (enqueue && !wr_ok) m_ovf = 1'b1;
    if (dequeue && mq.size() == 0) m_udf = 1'b1;
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) begin
      mq.push_back(wdata);
      sb.push_back(wdata);
    end
  endfunction

  task automatic step(bit en, bit de, logic [W-1:0] wd);
    enqueue = en;
    dequeue = de;
    wdata   = wd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: every settled cycle, check flags; pop on an accepted read.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("filled", 32'(filled), 32'(mq.size() >= THR));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`endif
        if (dequeue && !empty) begin
          if (sb.size() == 0) begin
            chk("sb_underrun", 32'(1), 32'(0));
          end else begin
            e = sb.pop_front();
            chk("rdata", 32'(rdata), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    enqueue = 1'b1;
    dequeue = 1'b0;
    wdata   = 30'h3;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_filled", 32'(filled), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    enqueue = 1'b0;
    rst_n   = 1'b1;

    step(1, 0, 30'h1);
    chk("first_rdata", 32'(rdata), 32'h1);
    chk("first_count", 32'(count), 32'd1);
    step(0, 1, 30'h0);

    for (int i = 0; i < DEPTH; i++) step(1, 0, W'(i));
    chk("fill_count", 32'(count), 32'd256);
    step(1, 0, 30'h3ff_ffff);
    chk("ovf_count", 32'(count), 32'd256);

    for (int i = 0; i < DEPTH; i++) step(0, 1, 30'h0);
    step(0, 1, 30'h0);
    chk("udf_count", 32'(count), 32'd0);

    step(1, 1, 30'h777);
    chk("empty_both_rdata", 32'(rdata), 32'h777);
    for (int i = 0; i < 4; i++) step(1, 0, W'($urandom));
    for (int i = 0; i < 1000; i++) step(1, 1, W'($urandom));
    chk("stream_count", 32'(count), 32'd5);

    while (mq.size() < DEPTH) step(1, 0, W'($urandom));
    step(1, 1, 30'h2aa_aaaa);
    chk("full_both_count", 32'(count), 32'd256);
    step(1, 1, 30'h155_5555);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, W'($urandom));

    while (mq.size() != 0) step(0, 1, 30'h0);
    for (int i = 0; i < 37; i++) step(1, 0, W'($urandom));
    chk("pre_rst_count", 32'(count), 32'd37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'(1));
    chk("async_count", 32'(count), 32'(0));
    chk("async_filled", 32'(filled), 32'(0));
    model_reset();
    enqueue = 1'b0;
    dequeue = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 0, W'(30'h100 + i));
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), W'($urandom));
    while (mq.size() != 0) step(0, 1, 30'h0);
    step(0, 0, 30'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_filled_sync.md
Name: fifo_filled_sync

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO with full, empty and programmable "filled" watermark flags.
- Used in the video pass-through datapath to buffer 30-bit TMDS symbol triplets.
- The filled flag throttles the upstream producer. The consumer pops whenever the FIFO is not empty.

Parameters:
- SIZE_SCALE, 8, log2 of depth; depth = 2**SIZE_SCALE entries.
- WIDTH, 30, data word width in bits.
- FILLED_THRESH, 128, occupancy at or above which filled asserts; legal range 1..2**SIZE_SCALE.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enqueue  in  1  write request.
- wdata  in  WIDTH  write data, sampled when a write is accepted.
- dequeue  in  1  read request; pops the head entry.
- rdata  out  WIDTH  head entry (FWFT), valid whenever empty=0.
- full  out  1  occupancy == 2**SIZE_SCALE.
- empty  out  1  occupancy == 0.
- filled  out  1  occupancy >= FILLED_THRESH.
- count  out  SIZE_SCALE+1  current occupancy.

Behaviour:
- State: write pointer, read pointer, occupancy count (SIZE_SCALE+1 bits), storage array of 2**SIZE_SCALE x WIDTH. The storage array is not reset.
- Reset (rst_n=0, asynchronous assert): pointers=0, count=0, empty=1, full=0, filled=0. Deassertion is sampled on clk; the first operation is accepted at the first rising edge with rst_n=1.
- Write accepted when enqueue=1 and (full=0, or dequeue=1 with empty=0). The accepted word is stored at the write pointer, and the pointer increments modulo depth.
- Read accepted when dequeue=1 and empty=0. The read pointer increments modulo depth.
- enqueue while full, without an accepted read: ignored; no state change and no data corruption.
- dequeue while empty: ignored; count stays 0.
- Simultaneous write and read:
  - Both accepted → count unchanged, including at full.
  - When empty, only the write is accepted, so count becomes 1.
- count update: +1 for a write only, -1 for a read only, 0 for both or neither.
- full, empty, filled and count are decoded from the registered count. They change in the cycle after the accepting edge, with no combinational path from enqueue or dequeue.
- FWFT: rdata = storage[read pointer] via an asynchronous read.
  - A word written at edge N is visible on rdata, with empty=0, in the cycle following edge N.
  - After a read at edge M, rdata shows the next entry in the cycle following edge M.
- rdata is don't-care while empty=1.
- Ordering is strictly first-in first-out across pointer wrap-around.
- Reset asserted mid-operation flushes all contents immediately. The flags return to their reset values asynchronously.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs, each 1 bit:
  - overflow: sticky; set on the edge where enqueue=1 and the write is rejected (full, no accepted read).
  - underflow: sticky; set on the edge where dequeue=1 while empty=1.
- Both flags are cleared only by rst_n=0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with enqueue=1 → empty=1, full=0, filled=0, count=0. Release and write 0x0000_0001 → next cycle empty=0, count=1, rdata=0x1.
- Fill: write 256 incrementing words with no reads → count reaches 128 and filled=1 the cycle after the 128th write. After the 256th write, full=1 and count=256. A 257th enqueue is ignored: count stays 256; with FIFO_ERR_FLAGS_EN, overflow=1.
- Drain: from full, hold dequeue=1 for 256 cycles → rdata sequence 0..255 in order. filled drops when count reaches 127, and empty=1 after the last read. One extra dequeue leaves count=0; with FIFO_ERR_FLAGS_EN, underflow=1.
- Streaming: enqueue and dequeue both asserted every cycle at count=5 for 1000 cycles, crossing pointer wrap → count constant at 5 and output order matches input.
- Simultaneous at boundaries:
  - empty + both asserted → count=1 and the written word appears on rdata.
  - full + both asserted → count stays 256 and the head advances.
- Asynchronous reset mid-stream: pull rst_n low between edges at count=37 → empty=1, count=0 without waiting for a clk edge. Subsequent writes start at a clean state.
